// File: rtl/demux1x2_stream_if.sv
// Stream interface for the registered 1-to-N demultiplexer.
// One upstream producer (in_*) and N_OUT downstream sinks sharing out_data,
// each sink addressed by its own out_valid/out_ready bit.
interface demux1x2_stream_if #(
    parameter int DATA_W = 32,
    parameter int N_OUT  = 2,
    parameter int SEL_W  = 1
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [SEL_W-1:0]  in_sel;
    logic [DATA_W-1:0] out_data;
    logic [N_OUT-1:0]  out_valid;
    logic [N_OUT-1:0]  out_ready;
    logic              sel_err;

    // Environment side: produces input words, acts as the sinks
    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_data, out_valid, sel_err
    );

    // Demultiplexer side
    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_data, out_valid, sel_err
    );
endinterface

// File: rtl/demux1x2_stream.sv
// Registered 1-to-N stream demultiplexer with valid/ready handshake.
// A single output register holds one word and presents it only to the sink
// selected at acceptance time. Words addressed to a non-existent sink are
// dropped and flagged with a one-cycle sel_err pulse.
// Optional feature macro: DEMUX_STATS_EN adds per-sink 16-bit delivery
// counters (stat_cnt) with a synchronous clear (stat_clr).
module demux1x2_stream #(
    parameter int DATA_W = 32,
    parameter int N_OUT  = 2,
    parameter int SEL_W  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
`ifdef DEMUX_STATS_EN
    input  logic                   stat_clr,
    output logic [N_OUT*16-1:0]    stat_cnt,
`endif
    demux1x2_stream_if.slave       bus
);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // N_OUT expressed in SEL_W+1 bits so the range check compares equal widths
    localparam logic [SEL_W:0] N_OUT_L = N_OUT[SEL_W:0];

    state_t             state_r, state_s;
    logic [DATA_W-1:0]  data_r, data_s;
    logic [SEL_W-1:0]   dst_r, dst_s;
    logic [N_OUT-1:0]   out_valid_r;
    logic               sel_err_r, sel_err_s;
    logic               sel_ready_s;
    logic               in_ready_s;
    logic               xfer_in_s;
    logic               xfer_out_s;
    logic               sel_ok_s;

    // Decode a sink index into its one-hot valid vector
    function automatic logic [N_OUT-1:0] dec_onehot(input logic [SEL_W-1:0] idx);
        logic [N_OUT-1:0] vec;
        vec = {N_OUT{1'b0}};
        for (int k = 0; k < N_OUT; k++) begin
            if (idx == SEL_W'(k)) begin
                vec[k] = 1'b1;
            end else begin
                vec[k] = 1'b0;
            end
        end
        return vec;
    endfunction

    // Ready of the currently addressed sink; other sinks' ready is ignored
    always_comb begin
        sel_ready_s = 1'b0;
        for (int k = 0; k < N_OUT; k++) begin
            if (dst_r == SEL_W'(k)) begin
                sel_ready_s = bus.out_ready[k];
            end else begin
                sel_ready_s = sel_ready_s;
            end
        end
    end

    // Handshake qualifiers; in_ready depends only on state and sink ready
    always_comb begin
        in_ready_s = (state_r == EMPTY) | sel_ready_s;
        xfer_in_s  = bus.in_valid & in_ready_s;
        xfer_out_s = (state_r == FULL) & sel_ready_s;
        sel_ok_s   = ({1'b0, bus.in_sel} < N_OUT_L);
    end

    // Next-state, next held word/destination and error pulse
    always_comb begin
        state_s   = state_r;
        data_s    = data_r;
        dst_s     = dst_r;
        sel_err_s = 1'b0;
        case (state_r)
            EMPTY: begin
                if (xfer_in_s && sel_ok_s) begin
                    state_s = FULL;
                    data_s  = bus.in_data;
                    dst_s   = bus.in_sel;
                end else if (xfer_in_s) begin
                    sel_err_s = 1'b1;
                end else begin
                    state_s = EMPTY;
                end
            end
            FULL: begin
                if (xfer_out_s && xfer_in_s && sel_ok_s) begin
                    state_s = FULL;
                    data_s  = bus.in_data;
                    dst_s   = bus.in_sel;
                end else if (xfer_out_s) begin
                    state_s   = EMPTY;
                    sel_err_s = xfer_in_s;
                end else begin
                    state_s = FULL;
                end
            end
            default: begin
                state_s = EMPTY;
            end
        endcase
    end

    // State and output registers; out_valid is derived from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= EMPTY;
            data_r      <= {DATA_W{1'b0}};
            dst_r       <= {SEL_W{1'b0}};
            out_valid_r <= {N_OUT{1'b0}};
            sel_err_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            data_r      <= data_s;
            dst_r       <= dst_s;
            out_valid_r <= (state_s == FULL) ? dec_onehot(dst_s) : {N_OUT{1'b0}};
            sel_err_r   <= sel_err_s;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_data  = data_r;
    assign bus.out_valid = out_valid_r;
    assign bus.sel_err   = sel_err_r;

`ifdef DEMUX_STATS_EN
    logic [15:0]      cnt_r [N_OUT];
    logic [N_OUT-1:0] deliver_s;

    // Which sink completes a delivery this cycle
    always_comb begin
        if (xfer_out_s) begin
            deliver_s = dec_onehot(dst_r);
        end else begin
            deliver_s = {N_OUT{1'b0}};
        end
    end

    // Per-sink delivery counters; clear wins over a same-cycle delivery
    always_ff @(posedge clk) begin
        for (int k = 0; k < N_OUT; k++) begin
            if (rst || stat_clr) begin
                cnt_r[k] <= 16'd0;
            end else if (deliver_s[k]) begin
                cnt_r[k] <= cnt_r[k] + 16'd1;
            end else begin
                cnt_r[k] <= cnt_r[k];
            end
        end
    end

    // Pack counters into the flat statistics port
    always_comb begin
        stat_cnt = {(N_OUT*16){1'b0}};
        for (int k = 0; k < N_OUT; k++) begin
            stat_cnt[16*k +: 16] = cnt_r[k];
        end
    end
`endif

endmodule

// File: tb/tb_demux1x2_stream.sv
// Scoreboard testbench for demux1x2_stream: accepted words are queued with
// their expected sink, and a negedge monitor pops and compares on delivery.
// A second instance (N_OUT=3, SEL_W=2) exercises out-of-range selects.
// Build with DEMUX_STATS_EN defined to also exercise the delivery counters.
module tb_demux1x2_stream;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    demux1x2_stream_if #(.DATA_W(32), .N_OUT(2), .SEL_W(1)) b2 ();
    demux1x2_stream_if #(.DATA_W(32), .N_OUT(3), .SEL_W(2)) b3 ();

`ifdef DEMUX_STATS_EN
    logic        stat_clr = 1'b0;
    logic [31:0] stat_cnt2;
    logic [47:0] stat_cnt3;
`endif

    demux1x2_stream #(.DATA_W(32), .N_OUT(2), .SEL_W(1)) dut2 (
        .clk      (clk),
        .rst      (rst),
`ifdef DEMUX_STATS_EN
        .stat_clr (stat_clr),
        .stat_cnt (stat_cnt2),
`endif
        .bus      (b2)
    );

    demux1x2_stream #(.DATA_W(32), .N_OUT(3), .SEL_W(2)) dut3 (
        .clk      (clk),
        .rst      (rst),
`ifdef DEMUX_STATS_EN
        .stat_clr (stat_clr),
        .stat_cnt (stat_cnt3),
`endif
        .bus      (b3)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [32:0] exp_q [$];   // {sink, data}

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic report_timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
    endtask

    // Offer one word to dut2; holds in_valid until accepted, returns #1 after the accepting edge
    task automatic send(input logic [31:0] d, input logic [0:0] s, output int waits);
        bit ok;
        ok    = 1'b0;
        waits = 0;
        b2.in_valid = 1'b1;
        b2.in_data  = d;
        b2.in_sel   = s;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (b2.in_ready) begin
                exp_q.push_back({s, d});
                ok = 1'b1;
            end else begin
                waits++;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) report_timeout("send");
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) return;
            @(negedge clk);
        end
        report_timeout("drain");
    endtask

    // Monitor: pop and compare on every delivery, and check held words never change
    bit          prev_hold = 1'b0;
    logic [31:0] prev_data;
    logic [1:0]  prev_valid;
    always @(negedge clk) begin
        logic [32:0] e;
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", 64'(b2.out_valid), 64'(prev_valid));
                check("hold_data", 64'(b2.out_data), 64'(prev_data));
            end
            prev_hold = 1'b0;
            if (b2.out_valid != 2'b00) begin
                check("onehot", 64'($countones(b2.out_valid)), 64'd1);
                if ((b2.out_valid & b2.out_ready) == 2'b00) begin
                    prev_hold  = 1'b1;
                    prev_valid = b2.out_valid;
                    prev_data  = b2.out_data;
                end
                for (int k = 0; k < 2; k++) begin
                    if (b2.out_valid[k] && b2.out_ready[k]) begin
                        if (exp_q.size() == 0) begin
                            n_vec++;
                            n_err++;
                            $display("FAIL unexpected_word: sink %0d data %0h, none expected", k, b2.out_data);
                        end else begin
                            e = exp_q.pop_front();
                            check("out_sink", 64'(k), 64'(e[32]));
                            check("out_data", 64'(b2.out_data), 64'(e[31:0]));
                        end
                    end
                end
            end
        end
    end

    initial begin
        int w;
        b2.in_valid = 1'b0; b2.in_data = 32'd0; b2.in_sel = 1'b0; b2.out_ready = 2'b00;
        b3.in_valid = 1'b0; b3.in_data = 32'd0; b3.in_sel = 2'd0; b3.out_ready = 3'b111;

        // 1. reset state
        rst = 1'b1;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(b2.out_valid), 64'd0);
        check("rst_out_data", 64'(b2.out_data), 64'd0);
        check("rst_sel_err", 64'(b2.sel_err), 64'd0);
        check("rst_in_ready", 64'(b2.in_ready), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        // 2. single word to sink 1, consumed on first presentation
        b2.out_ready = 2'b10;
        send(32'hDEADBEEF, 1'b1, w);
        b2.in_valid = 1'b0;
        @(negedge clk);
        check("t2_out_valid", 64'(b2.out_valid), 64'h2);
        check("t2_out_data", 64'(b2.out_data), 64'hDEADBEEF);
        @(negedge clk);
        check("t2_consumed", 64'(b2.out_valid), 64'd0);
        check("t2_data_kept", 64'(b2.out_data), 64'hDEADBEEF);
        @(posedge clk); #1;

        // 3. back-to-back words to sink 0 at full rate
        b2.out_ready = 2'b01;
        send(32'h1, 1'b0, w); check("t3_w1_stall", 64'(w), 64'd0);
        send(32'h2, 1'b0, w); check("t3_w2_stall", 64'(w), 64'd0);
        send(32'h3, 1'b0, w); check("t3_w3_stall", 64'(w), 64'd0);
        b2.in_valid = 1'b0;
        wait_drain();
        @(posedge clk); #1;

        // 4. word held while its sink stalls (other sink ready is ignored)
        b2.out_ready = 2'b10;
        send(32'hA5, 1'b0, w);
        b2.in_valid = 1'b1;
        b2.in_data  = 32'h5A;
        b2.in_sel   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_valid", 64'(b2.out_valid), 64'h1);
            check("t4_data", 64'(b2.out_data), 64'hA5);
            check("t4_in_ready", 64'(b2.in_ready), 64'd0);
        end
        @(posedge clk); #1;
        b2.in_valid  = 1'b0;
        b2.out_ready = 2'b01;
        wait_drain();
        @(posedge clk); #1;

        // reset while a word is held: discarded, no out_valid afterwards
        b2.out_ready = 2'b00;
        send(32'h55, 1'b0, w);
        b2.in_valid = 1'b0;
        void'(exp_q.pop_back());
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", 64'(b2.out_valid), 64'd0);
        check("mid_rst_data", 64'(b2.out_data), 64'd0);
        check("mid_rst_in_ready", 64'(b2.in_ready), 64'd1);
        @(posedge clk); #1;

        // 5. out-of-range select on the 3-sink instance
        b3.in_valid = 1'b1; b3.in_sel = 2'd3; b3.in_data = 32'h77;
        @(negedge clk);
        check("t5_in_ready", 64'(b3.in_ready), 64'd1);
        check("t5_no_err_yet", 64'(b3.sel_err), 64'd0);
        @(posedge clk); #1;
        b3.in_valid = 1'b0;
        @(negedge clk);
        check("t5_sel_err", 64'(b3.sel_err), 64'd1);
        check("t5_valid", 64'(b3.out_valid), 64'd0);
        @(negedge clk);
        check("t5_err_pulse", 64'(b3.sel_err), 64'd0);
        check("t5_valid2", 64'(b3.out_valid), 64'd0);
        @(posedge clk); #1;
        b3.out_ready = 3'b000;
        b3.in_valid = 1'b1; b3.in_sel = 2'd2; b3.in_data = 32'h99;
        @(posedge clk); #1;
        b3.in_valid = 1'b0;
        @(negedge clk);
        check("t5_sink2_valid", 64'(b3.out_valid), 64'h4);
        check("t5_sink2_data", 64'(b3.out_data), 64'h99);
        check("t5_sink2_err", 64'(b3.sel_err), 64'd0);
        @(posedge clk); #1;
        b3.out_ready = 3'b111;

`ifdef DEMUX_STATS_EN
        // 6. delivery counters with synchronous clear
        b2.out_ready = 2'b10;
        send(32'h10, 1'b1, w);
        send(32'h11, 1'b1, w);
        send(32'h12, 1'b1, w);
        b2.in_valid = 1'b0;
        wait_drain();
        @(posedge clk); @(negedge clk);
        check("t6_cnt_3", 64'(stat_cnt2[31:16]), 64'd3);
        check("t6_cnt0_0", 64'(stat_cnt2[15:0]), 64'd0);
        @(posedge clk); #1;
        stat_clr = 1'b1;
        @(posedge clk); #1;
        stat_clr = 1'b0;
        @(negedge clk);
        check("t6_cnt_clr", 64'(stat_cnt2[31:16]), 64'd0);
        @(posedge clk); #1;
        send(32'h13, 1'b1, w);
        b2.in_valid = 1'b0;
        wait_drain();
        @(posedge clk); @(negedge clk);
        check("t6_cnt_1", 64'(stat_cnt2[31:16]), 64'd1);
        @(posedge clk); #1;
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
